// File: rtl/video_timing_gen.sv
// Raster timing generator: sync / back porch / visible / front porch counters with registered, mutually aligned outputs.
// Define VTG_PREFETCH_EN to add pre_x/pre_y/pre_valid, which lead the beam outputs by LOOKAHEAD pixel advances.
module video_timing_gen #(
  parameter int H_VISIBLE = 1024,
  parameter int H_FRONT   = 24,
  parameter int H_SYNC    = 136,
  parameter int H_BACK    = 160,
  parameter int V_VISIBLE = 768,
  parameter int V_FRONT   = 3,
  parameter int V_SYNC    = 6,
  parameter int V_BACK    = 29,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int X_W       = 11,
  parameter int Y_W       = 10,
  parameter int LOOKAHEAD = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           pix_en,
  output logic [X_W-1:0] beam_x,
  output logic [Y_W-1:0] beam_y,
  output logic           valid,
  output logic           hsync,
  output logic           vsync,
  output logic           line_start,
`ifdef VTG_PREFETCH_EN
  output logic [X_W-1:0] pre_x,
  output logic [Y_W-1:0] pre_y,
  output logic           pre_valid,
`endif
  output logic           frame_start
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_VISIBLE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_VISIBLE + V_FRONT;
  localparam int H_START = H_SYNC + H_BACK;
  localparam int V_START = V_SYNC + V_BACK;
  localparam int H_END   = H_START + H_VISIBLE;
  localparam int V_END   = V_START + V_VISIBLE;

  generate
    if (H_VISIBLE < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
        V_VISIBLE < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1 ||
        X_W < 1 || Y_W < 1) begin : g_bad_width
      $fatal(1, "video_timing_gen: every timing and coordinate width must be >= 1");
    end
    if (longint'(H_TOTAL) > (longint'(1) << X_W)) begin : g_bad_htotal
      $fatal(1, "video_timing_gen: H_TOTAL does not fit in X_W bits");
    end
    if (longint'(V_TOTAL) > (longint'(1) << Y_W)) begin : g_bad_vtotal
      $fatal(1, "video_timing_gen: V_TOTAL does not fit in Y_W bits");
    end
    if (LOOKAHEAD < 1 || LOOKAHEAD > H_START) begin : g_bad_lookahead
      $fatal(1, "video_timing_gen: LOOKAHEAD must lie in 1..H_SYNC+H_BACK");
    end
  endgenerate

  localparam logic [X_W-1:0] H_LAST    = X_W'(H_TOTAL - 1);
  localparam logic [Y_W-1:0] V_LAST    = Y_W'(V_TOTAL - 1);
  localparam logic [X_W-1:0] H_START_X = X_W'(H_START);
  localparam logic [Y_W-1:0] V_START_Y = Y_W'(V_START);
  localparam logic [X_W-1:0] H_END_X   = X_W'(H_END);
  localparam logic [Y_W-1:0] V_END_Y   = Y_W'(V_END);
  localparam logic [X_W-1:0] H_SYNC_X  = X_W'(H_SYNC);
  localparam logic [Y_W-1:0] V_SYNC_Y  = Y_W'(V_SYNC);
  localparam logic [X_W-1:0] H_ONE     = X_W'(1);
  localparam logic [Y_W-1:0] V_ONE     = Y_W'(1);

  function automatic logic [X_W-1:0] h_step(input logic [X_W-1:0] h);
    return (h == H_LAST) ? '0 : h + H_ONE;
  endfunction

  function automatic logic [Y_W-1:0] v_step(input logic [X_W-1:0] h, input logic [Y_W-1:0] v);
    if (h != H_LAST) return v;
    return (v == V_LAST) ? '0 : v + V_ONE;
  endfunction

  function automatic logic in_visible(input logic [X_W-1:0] h, input logic [Y_W-1:0] v);
    return (h >= H_START_X) && (h < H_END_X) && (v >= V_START_Y) && (v < V_END_Y);
  endfunction

  logic [X_W-1:0] h_reg;
  logic [X_W-1:0] h_next;
  logic [Y_W-1:0] v_reg;
  logic [Y_W-1:0] v_next;
  logic           vis_next;

  // Outputs are computed from the post-advance position so they line up with the counters.
  always_comb begin
    h_next   = h_step(h_reg);
    v_next   = v_step(h_reg, v_reg);
    vis_next = in_visible(h_next, v_next);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      h_reg       <= H_LAST;
      v_reg       <= V_LAST;
      beam_x      <= '0;
      beam_y      <= '0;
      valid       <= 1'b0;
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (pix_en) begin
        h_reg       <= h_next;
        v_reg       <= v_next;
        valid       <= vis_next;
        beam_x      <= vis_next ? (h_next - H_START_X) : '0;
        beam_y      <= vis_next ? (v_next - V_START_Y) : '0;
        hsync       <= (h_next < H_SYNC_X) ? HSYNC_POL : ~HSYNC_POL;
        vsync       <= (v_next < V_SYNC_Y) ? VSYNC_POL : ~VSYNC_POL;
        line_start  <= (h_next == '0);
        frame_start <= (h_next == '0) && (v_next == '0);
      end
    end
  end

`ifdef VTG_PREFETCH_EN
  // A second counter pair starts LOOKAHEAD raster positions ahead; LOOKAHEAD <= H_START keeps it in line 0's blanking.
  localparam logic [X_W-1:0] PRE_H_INIT = X_W'(LOOKAHEAD - 1);

  logic [X_W-1:0] ph_reg;
  logic [X_W-1:0] ph_next;
  logic [Y_W-1:0] pv_reg;
  logic [Y_W-1:0] pv_next;
  logic           pre_vis_next;

  always_comb begin
    ph_next      = h_step(ph_reg);
    pv_next      = v_step(ph_reg, pv_reg);
    pre_vis_next = in_visible(ph_next, pv_next);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ph_reg    <= PRE_H_INIT;
      pv_reg    <= '0;
      pre_x     <= '0;
      pre_y     <= '0;
      pre_valid <= 1'b0;
    end else if (pix_en) begin
      ph_reg    <= ph_next;
      pv_reg    <= pv_next;
      pre_valid <= pre_vis_next;
      pre_x     <= pre_vis_next ? (ph_next - H_START_X) : '0;
      pre_y     <= pre_vis_next ? (pv_next - V_START_Y) : '0;
    end
  end
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen on a 7x5 raster (H 4/1/1/1, V 2/1/1/1, both polarities high).
// Stimulus pushes the expected observation per clock; a negedge monitor pops and compares.
module tb_video_timing_gen;
  localparam int HT = 7;
  localparam int VT = 5;
  localparam int FT = HT * VT;
  localparam int LA = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       pix_en = 1'b0;
  logic [2:0] beam_x;
  logic [2:0] beam_y;
  logic       valid;
  logic       hsync;
  logic       vsync;
  logic       line_start;
  logic       frame_start;
  logic [2:0] pre_x;
  logic [2:0] pre_y;
  logic       pre_valid;

  always #5 clk = ~clk;

  video_timing_gen #(
    .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
    .V_VISIBLE(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1),
    .X_W(3), .Y_W(3), .LOOKAHEAD(LA)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pix_en(pix_en),
    .beam_x(beam_x),
    .beam_y(beam_y),
    .valid(valid),
    .hsync(hsync),
    .vsync(vsync),
    .line_start(line_start),
`ifdef VTG_PREFETCH_EN
    .pre_x(pre_x),
    .pre_y(pre_y),
    .pre_valid(pre_valid),
`endif
    .frame_start(frame_start)
  );

`ifndef VTG_PREFETCH_EN
  assign pre_x = '0;
  assign pre_y = '0;
  assign pre_valid = 1'b0;
`endif

  typedef struct packed {
    logic [2:0] x;
    logic [2:0] y;
    logic       vld;
    logic       hs;
    logic       vs;
    logic       ls;
    logic       fs;
    logic [2:0] px;
    logic [2:0] py;
    logic       pv;
  } obs_t;

  obs_t q[$];
  int   total = 0;
  int   bad = 0;
  int   idx = FT - 1;

  // Raster index -> {x, y, valid, hsync, vsync}: visible at h 2..5, v 2..3; sync at h 0, v 0 (active high).
  function automatic logic [8:0] beam_of(input int i);
    int         h;
    int         v;
    logic       vis;
    logic [2:0] x;
    logic [2:0] y;
    h   = i % HT;
    v   = i / HT;
    vis = (h >= 2) && (h < 6) && (v >= 2) && (v < 4);
    x   = vis ? 3'(h - 2) : 3'd0;
    y   = vis ? 3'(v - 2) : 3'd0;
    return {x, y, vis, (h < 1), (v < 1)};
  endfunction

  function automatic obs_t expect_at(input int i, input logic ls, input logic fs);
    logic [8:0] b;
    logic [8:0] p;
    b = beam_of(i);
`ifdef VTG_PREFETCH_EN
    p = beam_of((i + LA) % FT);
`else
    p = '0;
`endif
    return {b, ls, fs, p[8:2]};
  endfunction

  task automatic cyc(input logic r, input logic e);
    logic ls;
    logic fs;
    rst = r;
    pix_en = e;
    @(posedge clk);
    ls = 1'b0;
    fs = 1'b0;
    if (!r) begin
      idx = FT - 1;
    end else if (e) begin
      idx = (idx + 1) % FT;
      ls  = (idx % HT == 0);
      fs  = (idx == 0);
    end
    q.push_back(expect_at(idx, ls, fs));
    #1;
  endtask

  initial begin : monitor
    obs_t exp_o;
    obs_t got;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        exp_o = q.pop_front();
        got = {beam_x, beam_y, valid, hsync, vsync, line_start, frame_start, pre_x, pre_y, pre_valid};
        total++;
        if (got !== exp_o) begin
          bad++;
          $display("FAIL obs%0d: got x=%0d y=%0d v=%b hs=%b vs=%b ls=%b fs=%b px=%0d py=%0d pv=%b want x=%0d y=%0d v=%b hs=%b vs=%b ls=%b fs=%b px=%0d py=%0d pv=%b",
                   total, got.x, got.y, got.vld, got.hs, got.vs, got.ls, got.fs, got.px, got.py, got.pv,
                   exp_o.x, exp_o.y, exp_o.vld, exp_o.hs, exp_o.vs, exp_o.ls, exp_o.fs, exp_o.px, exp_o.py, exp_o.pv);
        end else begin
          $display("txn %0d ok: x=%0d y=%0d v=%b hs=%b vs=%b ls=%b fs=%b px=%0d py=%0d pv=%b",
                   total, got.x, got.y, got.vld, got.hs, got.vs, got.ls, got.fs, got.px, got.py, got.pv);
        end
      end
    end
  end

  initial begin : stimulus
    logic [15:0] pat;
    pat = 16'b1101_0011_1110_0101;
    // Reset with pix_en high: must be ignored.
    repeat (3) cyc(1'b0, 1'b1);
    // Continuous advance: more than two frames, crossing h and v wraps.
    repeat (80) cyc(1'b1, 1'b1);
    // Alternating enable: periods double, strobes stay one clock.
    repeat (20) begin
      cyc(1'b1, 1'b1);
      cyc(1'b1, 1'b0);
    end
    // Irregular enable gaps.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 16; i++) cyc(1'b1, pat[i]);
    end
    // Mid-frame reset, release with enable low, then first advance must enter (0,0).
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    repeat (45) cyc(1'b1, 1'b1);
    repeat (4) @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending observations want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 Parameter H_VISIBLE, default 1024, visible pixels per line.
REQ-002 Parameters H_FRONT / H_SYNC / H_BACK, defaults 24 / 136 / 160, horizontal porch and sync widths in pixels.
REQ-003 Parameters V_VISIBLE / V_FRONT / V_SYNC / V_BACK, defaults 768 / 3 / 6 / 29, same in lines.
REQ-004 Parameters HSYNC_POL / VSYNC_POL, default 0 / 0, active level of each sync output.
REQ-005 Parameters X_W / Y_W, default 11 / 10, coordinate widths.
REQ-006 Parameter LOOKAHEAD, default 2, prefetch distance in pixel advances (used only with VTG_PREFETCH_EN).
REQ-007 clk  input  1  single clock, rising edge.
REQ-008 rst  input  1  synchronous, active-low reset.
REQ-009 pix_en  input  1  pixel-advance enable.
REQ-010 beam_x  output  X_W  visible column, 0 outside visible area.
REQ-011 beam_y  output  Y_W  visible row, 0 outside visible area.
REQ-012 valid  output  1  high inside visible area.
REQ-013 hsync, vsync  output  1 each  sync pulses at configured polarity.
REQ-014 line_start, frame_start  output  1 each  single-clk strobes.
REQ-015 pre_x, pre_y, pre_valid  output  X_W, Y_W, 1  prefetch position, present only with VTG_PREFETCH_EN.

Function
REQ-016 H_TOTAL = sum of H params; V_TOTAL likewise. Internal h in 0..H_TOTAL-1, v in 0..V_TOTAL-1.
REQ-017 Region order per line and frame: sync, back porch, visible, front porch. H_START = H_SYNC+H_BACK; V_START = V_SYNC+V_BACK.
REQ-018 On a clk edge with pix_en=1: h increments; at H_TOTAL-1 it wraps to 0 and v increments; v wraps from V_TOTAL-1 to 0 on the same edge.
REQ-019 On a clk edge with pix_en=0: counters and level outputs hold; strobes load 0.
REQ-020 All outputs are registered and mutually aligned: after each advancing edge they describe the new (h,v).
REQ-021 valid = (H_START <= h < H_START+H_VISIBLE) and (V_START <= v < V_START+V_VISIBLE). beam_x = h-H_START, beam_y = v-V_START when valid, else 0.
REQ-022 hsync = HSYNC_POL when h < H_SYNC, else its inverse; vsync = VSYNC_POL when v < V_SYNC, else its inverse.
REQ-023 line_start is 1 for exactly one clk after an advancing edge that enters h=0; frame_start is 1 likewise on entering (0,0).
REQ-024 Parameter checks at elaboration: every width >= 1; H_TOTAL <= 2^X_W; V_TOTAL <= 2^Y_W; 1 <= LOOKAHEAD <= H_START. Any violation is a fatal elaboration error.

Reset
REQ-025 While rst=0 at a clk edge: h=H_TOTAL-1, v=V_TOTAL-1, beam_x=0, beam_y=0, valid=0, hsync=!HSYNC_POL, vsync=!VSYNC_POL, strobes 0. pix_en is ignored.
REQ-026 Reset asserted mid-frame takes effect on the next edge. The first advancing edge after release enters (0,0) and raises line_start and frame_start.

Configuration
REQ-027 With VTG_PREFETCH_EN defined: pre_x/pre_y/pre_valid always equal the beam_x/beam_y/valid values that appear LOOKAHEAD advances later, including across line and frame wraps. They advance and hold with pix_en. At reset they describe raster index LOOKAHEAD-1, so pre_valid=0, pre_x=0 and pre_y=0.
REQ-028 With VTG_PREFETCH_EN undefined: the pre_* ports and all prefetch logic are absent; all other behaviour is identical.

Verification
REQ-029 Defaults, pix_en=1: hsync low 136 clks, first valid at h=296 with beam_x 0..1023, line period 1344, frame period 1083264, one frame_start per frame.
REQ-030 pix_en alternating 1/0: all periods double; each strobe stays one clk wide.
REQ-031 H 4/1/1/1, V 2/1/1/1, POL=1: exact 7x5 raster with hsync high at h=0, valid at h=2..5 and v=2..3, beam_x 0..3.
REQ-032 rst=0 at h=500, v=300: reset values on the next edge; after release, the first advance raises frame_start.
REQ-033 VTG_PREFETCH_EN, LOOKAHEAD=2: pre_* equal beam/valid two advances later at h wrap, at v wrap, and with pix_en gaps.
REQ-034 H_TOTAL=2049 with X_W=11: elaboration fails.
